// File: rtl/sobel_grad_pipe.sv
// -----------------------------------------------------------------------------
// sobel_grad_pipe
// Parametrised Sobel gradient engine. Each accepted beat carries a 3-row x
// (NUM_WIN+2)-column pixel buffer; NUM_WIN adjacent 3x3 windows are evaluated
// in parallel. Window k uses columns k..k+2 and produces signed Gx, signed Gy
// and the unsigned magnitude |Gx|+|Gy|, clamped to MAG_W bits when MAG_W is
// narrower than PIX_W+3.
//
// Pipeline: S1 weighted column/row sums, S2 signed differences, S3 abs+add.
// Each stage holds a valid bit and loads when its successor is empty or moving,
// so bubbles collapse forward while the output is stalled.
//
// Ports:
//   clk, n_rst          clock (rising edge), async active-low reset
//   in_data             pixel (r,c) at [(r*(NUM_WIN+2)+c)*PIX_W +: PIX_W]
//   in_valid/in_ready   input handshake (in_ready does not look at in_valid)
//   out_valid/out_ready output handshake
//   gx_out, gy_out      signed, window k at [k*(PIX_W+3) +: PIX_W+3]
//   mag_out             unsigned, window k at [k*MAG_W +: MAG_W]
//   beat_cnt            accepted input beats, wraps 0xFFFF -> 0
//
// Optional feature, macro SOBEL_THRESH_EN:
//   thresh   in   MAG_W    edge threshold, sampled when S3 loads
//   edge_out out  NUM_WIN  bit k set when mag_k >= thresh, registered with mag_out
//   edge_cnt out  16       set edge bits summed per output transfer, saturating
// -----------------------------------------------------------------------------
module sobel_grad_pipe #(
  parameter int PIX_W   = 8,
  parameter int NUM_WIN = 2,
  parameter int MAG_W   = 11
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [3*(NUM_WIN+2)*PIX_W-1:0]   in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_WIN*(PIX_W+3)-1:0]     gx_out,
  output logic [NUM_WIN*(PIX_W+3)-1:0]     gy_out,
  output logic [NUM_WIN*MAG_W-1:0]         mag_out,
  output logic [15:0]                      beat_cnt
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [MAG_W-1:0]                 thresh,
  output logic [NUM_WIN-1:0]               edge_out,
  output logic [15:0]                      edge_cnt
`endif
);

  localparam int COLS = NUM_WIN + 2;
  localparam int SW   = PIX_W + 2;   // weighted 1-2-1 sum width
  localparam int GW   = PIX_W + 3;   // signed gradient / raw magnitude width
  localparam int XW   = (MAG_W > GW) ? MAG_W : GW;
  localparam logic [XW-1:0] MAG_MAX = {XW{1'b1}} >> (XW - MAG_W);

  function automatic logic [PIX_W-1:0] px(input logic [3*COLS*PIX_W-1:0] d,
                                          input int r, input int c);
    return d[(r*COLS+c)*PIX_W +: PIX_W];
  endfunction

  function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [GW-1:0] abs_s(input logic [GW-1:0] v);
    logic [GW-1:0] r;
    if (v[GW-1]) r = -v;
    else         r = v;
    return r;
  endfunction

  logic                    r_v1, r_v2, r_v3;
  logic                    w_ld1, w_ld2, w_ld3, w_acc;
  logic [NUM_WIN*SW-1:0]   r_cl, r_cr, r_rt, r_rb;
  logic [NUM_WIN*SW-1:0]   w_cl, w_cr, w_rt, w_rb;
  logic [NUM_WIN*GW-1:0]   r_gx, r_gy, w_gx, w_gy;
  logic [NUM_WIN*GW-1:0]   r_gx3, r_gy3, w_sum;
  logic [NUM_WIN*XW-1:0]   w_sumx;
  logic [NUM_WIN*MAG_W-1:0] r_mag3, w_mag;
  logic [15:0]             r_beat;

  // A stage may load when it is empty or its content moves on this cycle.
  assign w_ld3    = !r_v3 | out_ready;
  assign w_ld2    = !r_v2 | w_ld3;
  assign w_ld1    = !r_v1 | w_ld2;
  assign w_acc    = in_valid & w_ld1;
  assign in_ready = w_ld1;

  assign out_valid = r_v3;
  assign gx_out    = r_gx3;
  assign gy_out    = r_gy3;
  assign mag_out   = r_mag3;
  assign beat_cnt  = r_beat;

  // S1 combinational: left/right column sums and top/bottom row sums.
  always_comb begin
    w_cl = '0;
    w_cr = '0;
    w_rt = '0;
    w_rb = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      w_cl[k*SW +: SW] = wsum(px(in_data, 0, k),   px(in_data, 1, k),   px(in_data, 2, k));
      w_cr[k*SW +: SW] = wsum(px(in_data, 0, k+2), px(in_data, 1, k+2), px(in_data, 2, k+2));
      w_rt[k*SW +: SW] = wsum(px(in_data, 0, k),   px(in_data, 0, k+1), px(in_data, 0, k+2));
      w_rb[k*SW +: SW] = wsum(px(in_data, 2, k),   px(in_data, 2, k+1), px(in_data, 2, k+2));
    end
  end

  // S2 combinational: differences, one extra bit keeps them exact and signed.
  always_comb begin
    w_gx = '0;
    w_gy = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      w_gx[k*GW +: GW] = {1'b0, r_cr[k*SW +: SW]} - {1'b0, r_cl[k*SW +: SW]};
      w_gy[k*GW +: GW] = {1'b0, r_rb[k*SW +: SW]} - {1'b0, r_rt[k*SW +: SW]};
    end
  end

  // S3 combinational: |Gx|+|Gy| fits GW unsigned; clamp only bites if MAG_W < GW.
  always_comb begin
    w_sum  = '0;
    w_sumx = '0;
    w_mag  = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      w_sum[k*GW +: GW]  = abs_s(r_gx[k*GW +: GW]) + abs_s(r_gy[k*GW +: GW]);
      w_sumx[k*XW +: XW] = XW'(w_sum[k*GW +: GW]);
      if (w_sumx[k*XW +: XW] > MAG_MAX) w_mag[k*MAG_W +: MAG_W] = MAG_MAX[MAG_W-1:0];
      else                              w_mag[k*MAG_W +: MAG_W] = w_sumx[k*XW +: MAG_W];
    end
  end

  // Stage valid bits and accepted-beat counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_beat <= 16'h0000;
    end else begin
      if (w_ld1) r_v1 <= in_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
      if (w_acc) r_beat <= r_beat + 16'h0001;
    end
  end

  // Data registers load only when a valid beat moves into the stage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cl   <= '0;
      r_cr   <= '0;
      r_rt   <= '0;
      r_rb   <= '0;
      r_gx   <= '0;
      r_gy   <= '0;
      r_gx3  <= '0;
      r_gy3  <= '0;
      r_mag3 <= '0;
    end else begin
      if (w_acc) begin
        r_cl <= w_cl;
        r_cr <= w_cr;
        r_rt <= w_rt;
        r_rb <= w_rb;
      end
      if (w_ld2 && r_v1) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
      end
      if (w_ld3 && r_v2) begin
        r_gx3  <= r_gx;
        r_gy3  <= r_gy;
        r_mag3 <= w_mag;
      end
    end
  end

`ifdef SOBEL_THRESH_EN
  function automatic logic [15:0] popcnt(input logic [NUM_WIN-1:0] v);
    logic [15:0] n;
    n = 16'h0000;
    for (int i = 0; i < NUM_WIN; i++) n = n + {15'h0000, v[i]};
    return n;
  endfunction

  logic [NUM_WIN-1:0] r_edge, w_edge;
  logic [15:0]        r_ecnt;
  logic [16:0]        w_ecnt_sum;

  assign edge_out = r_edge;
  assign edge_cnt = r_ecnt;

  // Threshold compare on the magnitude about to enter S3.
  always_comb begin
    w_edge = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      w_edge[k] = (w_mag[k*MAG_W +: MAG_W] >= thresh);
    end
    w_ecnt_sum = {1'b0, r_ecnt} + {1'b0, popcnt(r_edge)};
  end

  // Edge flags travel with mag_out; edge count saturates at all-ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_edge <= '0;
      r_ecnt <= 16'h0000;
    end else begin
      if (w_ld3 && r_v2) r_edge <= w_edge;
      if (r_v3 && out_ready) r_ecnt <= w_ecnt_sum[16] ? 16'hFFFF : w_ecnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_sobel_grad_pipe.sv
module tb_sobel_grad_pipe;
  localparam int PW = 8;
  localparam int NW = 2;
  localparam int DW = 3*(NW+2)*PW;

  typedef struct packed {
    logic [31:0] cyc;
    logic [21:0] gx;
    logic [21:0] gy;
    logic [21:0] mag;
    logic [19:0] mag10;
    logic [1:0]  edg;
  } res_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, s_in_ready, s_out_valid;
  logic [21:0]   gx_out, gy_out, mag_out, s_gx, s_gy;
  logic [19:0]   s_mag;
  logic [15:0]   beat_cnt, s_beat;
`ifdef SOBEL_THRESH_EN
  logic [10:0]   thresh = 11'd0;
  logic [9:0]    thresh10 = 10'd0;
  logic [1:0]    edge_out, s_edge;
  logic [15:0]   edge_cnt, s_ecnt;
`endif

  always #5 clk = ~clk;

  sobel_grad_pipe #(.PIX_W(8), .NUM_WIN(2), .MAG_W(11)) u_dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .gx_out(gx_out), .gy_out(gy_out), .mag_out(mag_out), .beat_cnt(beat_cnt)
`ifdef SOBEL_THRESH_EN
    , .thresh(thresh), .edge_out(edge_out), .edge_cnt(edge_cnt)
`endif
  );

  sobel_grad_pipe #(.PIX_W(8), .NUM_WIN(2), .MAG_W(10)) u_sat (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
    .gx_out(s_gx), .gy_out(s_gy), .mag_out(s_mag), .beat_cnt(s_beat)
`ifdef SOBEL_THRESH_EN
    , .thresh(thresh10), .edge_out(s_edge), .edge_cnt(s_ecnt)
`endif
  );

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     th_cur = 0;
  int     pair_bad = 0;
  bit     rec = 1'b1;
  res_t   exp_q[$];
  res_t   obs_q[$];
  logic        snap_ir, snap_ov;
  logic [21:0] snap_gx, snap_mag;

  // Reference: Sobel sums from plain integer arithmetic on the pixel grid.
  function automatic res_t model(input logic [DW-1:0] d, input int th, input int cy);
    res_t e;
    int p[3][4];
    int gx, gy, m;
    e = '0;
    e.cyc = 32'(cy);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        p[r][c] = int'(d[(r*4+c)*8 +: 8]);
    for (int k = 0; k < NW; k++) begin
      gx = (p[0][k+2] + 2*p[1][k+2] + p[2][k+2]) - (p[0][k] + 2*p[1][k] + p[2][k]);
      gy = (p[2][k] + 2*p[2][k+1] + p[2][k+2]) - (p[0][k] + 2*p[0][k+1] + p[0][k+2]);
      m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      e.gx[k*11 +: 11]   = 11'(gx);
      e.gy[k*11 +: 11]   = 11'(gy);
      e.mag[k*11 +: 11]  = 11'(m);
      e.mag10[k*10 +: 10] = 10'(m > 1023 ? 1023 : m);
      e.edg[k] = (m >= th);
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] grid(input int kind);
    logic [DW-1:0] d;
    logic [7:0] v;
    d = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        case (kind)
          0: v = (c >= 2) ? 8'd255 : 8'd0;               // vertical edge
          1: v = (r == 0) ? 8'd255 : 8'd0;               // horizontal edge
          2: v = (c >= 2 || r == 2) ? 8'd255 : 8'd0;     // corner, large magnitude
          default: v = 8'd128;                           // uniform
        endcase
        d[(r*4+c)*8 +: 8] = v;
      end
    return d;
  endfunction

  // One clock: drive after the falling edge, observe 1 time unit later.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic ordy);
    res_t o;
    in_valid = v;
    in_data = d;
    out_ready = ordy;
    #1;
    snap_ir = in_ready;
    snap_ov = out_valid;
    snap_gx = gx_out;
    snap_mag = mag_out;
    if (s_in_ready !== in_ready || s_out_valid !== out_valid || s_gx !== gx_out ||
        s_gy !== gy_out || s_beat !== beat_cnt) pair_bad++;
`ifdef SOBEL_THRESH_EN
    if (s_edge !== edge_out || s_ecnt !== edge_cnt) pair_bad++;
`endif
    if (rec && n_rst && v && in_ready) exp_q.push_back(model(d, th_cur, cyc));
    if (rec && n_rst && out_valid && out_ready) begin
      o = '0;
      o.cyc = 32'(cyc);
      o.gx = gx_out;
      o.gy = gy_out;
      o.mag = mag_out;
      o.mag10 = s_mag;
`ifdef SOBEL_THRESH_EN
      o.edg = edge_out;
`endif
      obs_q.push_back(o);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (obs_q.size() >= exp_q.size()) break;
      cycle(1'b0, '0, 1'b1);
    end
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    res_t o, e;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 16'h0000 || gx_out !== 22'h0 || gy_out !== 22'h0 || mag_out !== 22'h0) begin
      errors++;
      $display("FAIL reset_state: got ov=%b cnt=%h gx=%h gy=%h mag=%h want all zero", out_valid, beat_cnt, gx_out, gy_out, mag_out);
    end
    n_rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, {$urandom, $urandom, $urandom}, 1'b0);
    checks++;
    if (beat_cnt !== 16'd3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: got cnt=%0d ir=%b ov=%b want 3 0 1", beat_cnt, in_ready, out_valid);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 16'h0000 || gx_out !== 22'h0 || gy_out !== 22'h0 || mag_out !== 22'h0) begin
      errors++;
      $display("FAIL reset_midstream: got ov=%b cnt=%h gx=%h gy=%h mag=%h want all zero", out_valid, beat_cnt, gx_out, gy_out, mag_out);
    end
    @(negedge clk);
    n_rst = 1'b1;
    exp_q.delete();
    obs_q.delete();
    cycle(1'b1, grid(0), 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b1);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL reset_after_count: got %0d results want 1", obs_q.size());
    end else begin
      o = obs_q[0];
      e = exp_q[0];
      checks++;
      if (o.cyc - e.cyc !== 32'd3 || o.gx !== e.gx || o.mag !== e.mag) begin
        errors++;
        $display("FAIL reset_after_beat: got lat=%0d gx=%h mag=%h want lat=3 gx=%h mag=%h", o.cyc - e.cyc, o.gx, o.mag, e.gx, e.mag);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_patterns();
    res_t o, e;
    for (int k = 0; k < 3; k++) cycle(1'b1, grid(k), 1'b1);
    drain();
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL patterns_count: got %0d want 3", obs_q.size());
    end else begin
      o = obs_q[0];
      checks++;
      if ({o.gx, o.gy, o.mag} !== {11'd1020, 11'd1020, 11'd0, 11'd0, 11'd1020, 11'd1020}) begin
        errors++;
        $display("FAIL vertical_edge: got gx=%h gy=%h mag=%h want gx=1020x2 gy=0 mag=1020x2", o.gx, o.gy, o.mag);
      end
      o = obs_q[1];
      checks++;
      // 11'h404 is -1020 in 11-bit two's complement
      if ({o.gx, o.gy, o.mag} !== {11'd0, 11'd0, 11'h404, 11'h404, 11'd1020, 11'd1020}) begin
        errors++;
        $display("FAIL horizontal_edge: got gx=%h gy=%h mag=%h want gx=0 gy=-1020x2 mag=1020x2", o.gx, o.gy, o.mag);
      end
      // Gx and Gy share the corner pixel, so one window peaks at 765/765 -> 1530.
      o = obs_q[2];
      checks++;
      if (o.gx[10:0] !== 11'd765 || o.gy[10:0] !== 11'd765 || o.mag[10:0] !== 11'd1530 || o.mag10[9:0] !== 10'd1023) begin
        errors++;
        $display("FAIL saturation: got gx=%0d gy=%0d mag11=%0d mag10=%0d want 765 765 1530 1023", o.gx[10:0], o.gy[10:0], o.mag[10:0], o.mag10[9:0]);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.gx !== e.gx || o.gy !== e.gy || o.mag !== e.mag || o.mag10 !== e.mag10) begin
        errors++;
        $display("FAIL patterns_model: got %h/%h/%h/%h want %h/%h/%h/%h", o.gx, o.gy, o.mag, o.mag10, e.gx, e.gy, e.mag, e.mag10);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, $urandom_range(0, 2) != 0);
    for (int i = 0; i < 100; i++) cycle(1'b1, {$urandom, $urandom, $urandom}, 1'b1);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() < 100) begin
      errors++;
      $display("FAIL stream_count: got %0d results want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.gx !== e.gx || o.gy !== e.gy || o.mag !== e.mag || o.mag10 !== e.mag10) begin
        errors++;
        $display("FAIL stream_data: got %h/%h/%h/%h want %h/%h/%h/%h", o.gx, o.gy, o.mag, o.mag10, e.gx, e.gy, e.mag, e.mag10);
      end
    end
    checks++;
    if (pair_bad !== 0) begin errors++; $display("FAIL instance_agree: got %0d disagreements want 0", pair_bad); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    res_t o, e;
    logic [21:0] hold_gx, hold_mag;
    int sent;
    logic [DW-1:0] d;
    sent = 0;
    hold_gx = '0;
    hold_mag = '0;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      d = {$urandom, $urandom, $urandom};
      d[7:0] = 8'(sent * 25);
      cycle(1'b1, d, !(c >= 4 && c <= 9));
      if (snap_ir) sent++;
      if (c == 4) begin
        hold_gx = snap_gx;
        hold_mag = snap_mag;
      end
      if (c >= 4 && c <= 9) begin
        checks++;
        if (snap_ir !== 1'b0 || snap_ov !== 1'b1 || snap_gx !== hold_gx || snap_mag !== hold_mag) begin
          errors++;
          $display("FAIL stall_hold c=%0d: got ir=%b ov=%b gx=%h mag=%h want 0 1 %h %h", c, snap_ir, snap_ov, snap_gx, snap_mag, hold_gx, hold_mag);
        end
      end
    end
    drain();
    checks++;
    if (obs_q.size() != 10 || exp_q.size() != 10) begin
      errors++;
      $display("FAIL stall_count: got %0d results of %0d sent want 10", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.gx !== e.gx || o.gy !== e.gy || o.mag !== e.mag) begin
        errors++;
        $display("FAIL stall_order: got %h/%h/%h want %h/%h/%h", o.gx, o.gy, o.mag, e.gx, e.gy, e.mag);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

`ifdef SOBEL_THRESH_EN
  task automatic test_thresh();
    res_t o, e;
    pulse_reset();
    th_cur = 500;
    thresh = 11'd500;
    thresh10 = 10'd500;
    cycle(1'b1, grid(0), 1'b1);
    cycle(1'b1, grid(3), 1'b1);
    drain();
    repeat (2) cycle(1'b0, '0, 1'b1);
    checks++;
    if (obs_q.size() != 2 || obs_q[0].edg !== 2'b11 || obs_q[1].edg !== 2'b00) begin
      errors++;
      $display("FAIL thresh_edges: got %0d results first=%b second=%b want 11 00", obs_q.size(), obs_q[0].edg, obs_q[1].edg);
    end
    checks++;
    if (edge_cnt !== 16'd2) begin errors++; $display("FAIL thresh_count: got %0d want 2", edge_cnt); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.edg !== e.edg) begin errors++; $display("FAIL thresh_model: got %b want %b", o.edg, e.edg); end
    end
    th_cur = 0;
    thresh = 11'd0;
    thresh10 = 10'd0;
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  task automatic test_beat_wrap();
    pulse_reset();
    rec = 1'b0;
    for (int i = 0; i < 65535; i++) cycle(1'b1, grid(i % 4), 1'b1);
    checks++;
    if (beat_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_top: got %h want ffff", beat_cnt); end
    cycle(1'b1, grid(0), 1'b1);
    checks++;
    if (beat_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", beat_cnt); end
    repeat (5) cycle(1'b0, '0, 1'b1);
`ifdef SOBEL_THRESH_EN
    checks++;
    if (edge_cnt !== 16'hFFFF) begin errors++; $display("FAIL edge_cnt_sat: got %h want ffff", edge_cnt); end
`endif
    rec = 1'b1;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_backpressure();
`ifdef SOBEL_THRESH_EN
    test_thresh();
`endif
    test_beat_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
